// File: rtl/game_soc_keys_pio.sv
// Avalon-MM input PIO for board keys/switches: synchronises in_port, latches
// selected edges per bit (write-1-to-clear) and raises a masked level interrupt.
module game_soc_keys_pio #(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] sync_d_reg;
  logic [ARM_W-1:0] arm_reg;
  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] edge_cap_reg;
  logic [WIDTH-1:0] edge_cap_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_term;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_mux;
  logic             reg_write;
  logic             armed;

  assign sync_in   = sync_reg[SYNC_STAGES-1];
  assign reg_write = chipselect & ~write_n;
  assign armed     = (arm_reg == ARM_MAX);

  assign rise = sync_in & ~sync_d_reg;
  assign fall = ~sync_in & sync_d_reg;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_raw = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_raw = fall;
    end else begin : g_any
      assign edge_raw = rise | fall;
    end
  endgenerate

  // Edges are suppressed until the chain has filled with real input values.
  assign edge_term = armed ? edge_raw : '0;
  assign w1c = (reg_write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A new edge beats a simultaneous clear of the same bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cap
      assign edge_cap_next[gi] = edge_term[gi] | (edge_cap_reg[gi] & ~w1c[gi]);
    end
  endgenerate

  generate
    if (WIDTH < 32) begin : g_wd_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = sync_in;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask_reg;
      2'd3:    rd_mux[WIDTH-1:0] = edge_cap_reg;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_reg     <= '0;
      sync_d_reg   <= '0;
      arm_reg      <= '0;
      irq_mask_reg <= '0;
      edge_cap_reg <= '0;
      readdata     <= '0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
      end else begin
        sync_reg <= in_port;
      end
      sync_d_reg <= sync_in;
      if (!armed) begin
        arm_reg <= arm_reg + 1'b1;
      end
      if (reg_write && address == 2'd2) begin
        irq_mask_reg <= writedata[WIDTH-1:0];
      end
      edge_cap_reg <= edge_cap_next;
      if (chipselect) begin
        readdata <= rd_mux;
      end
    end
  end

  assign irq = |(edge_cap_reg & irq_mask_reg);

endmodule

// File: tb/tb_game_soc_keys_pio.sv
// Directed bench for game_soc_keys_pio: vector table for the register map plus
// hand sequences for reset, edge latency, set/clear collision and arming.
module tb_game_soc_keys_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] readdata_a;
  logic        irq_a;

  int n_checks = 0;
  int n_fail   = 0;

  game_soc_keys_pio #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // Any-edge instance on the same bus, used to observe the arming window.
  game_soc_keys_pio #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_a), .irq(irq_a)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [3:0]  in_val;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'hF, 1'b0, 2'd0, 32'h0,    32'hF, 1'b0};
    vecs[1]  = '{4'hF, 1'b0, 2'd1, 32'h0,    32'h0, 1'b0};
    vecs[2]  = '{4'hF, 1'b1, 2'd0, 32'hFFFF, 32'h0, 1'b0};
    vecs[3]  = '{4'hF, 1'b0, 2'd0, 32'h0,    32'hF, 1'b0};
    vecs[4]  = '{4'hD, 1'b0, 2'd3, 32'h0,    32'h2, 1'b0};
    vecs[5]  = '{4'hF, 1'b0, 2'd3, 32'h0,    32'h2, 1'b0};
    vecs[6]  = '{4'hF, 1'b1, 2'd2, 32'h1,    32'h0, 1'b0};
    vecs[7]  = '{4'hF, 1'b0, 2'd2, 32'h0,    32'h1, 1'b0};
    vecs[8]  = '{4'hF, 1'b1, 2'd2, 32'h3,    32'h0, 1'b1};
    vecs[9]  = '{4'hB, 1'b0, 2'd3, 32'h0,    32'h6, 1'b1};
    vecs[10] = '{4'hB, 1'b1, 2'd3, 32'h2,    32'h0, 1'b0};
    vecs[11] = '{4'hB, 1'b0, 2'd3, 32'h0,    32'h4, 1'b0};
    vecs[12] = '{4'hB, 1'b1, 2'd3, 32'h0,    32'h0, 1'b0};
    vecs[13] = '{4'hB, 1'b0, 2'd3, 32'h0,    32'h4, 1'b0};
    vecs[14] = '{4'hB, 1'b1, 2'd2, 32'hF,    32'h0, 1'b1};
    vecs[15] = '{4'hB, 1'b1, 2'd3, 32'hF,    32'h0, 1'b0};
    vecs[16] = '{4'hB, 1'b0, 2'd3, 32'h0,    32'h0, 1'b0};
    vecs[17] = '{4'hF, 1'b0, 2'd0, 32'h0,    32'hF, 1'b0};
    vecs[18] = '{4'h0, 1'b0, 2'd3, 32'h0,    32'hF, 1'b1};
    vecs[19] = '{4'h0, 1'b1, 2'd3, 32'hF,    32'h0, 1'b0};
    vecs[20] = '{4'h0, 1'b0, 2'd0, 32'h0,    32'h0, 1'b0};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'hF;

    // Reset values and arming with inputs already high
    repeat (3) @(negedge clk);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_readdata", readdata, 32'h0);
    check("post_reset_irq", {31'h0, irq}, 32'h0);
    repeat (4) @(negedge clk);
    bus_read(2'd0);
    check("armed_data", readdata, 32'h0000000F);
    bus_read(2'd3);
    check("armed_edgecap", readdata, 32'h0);
    check("armed_edgecap_any", readdata_a, 32'h0);

    // Register map vectors
    for (int i = 0; i < 21; i++) begin
      in_port = vecs[i].in_val;
      repeat (4) @(negedge clk);
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        bus_read(vecs[i].addr);
        check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      end
      check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
    end

    // Exact capture latency: SYNC_STAGES+1 clocks (mask is F, capture is 0)
    in_port = 4'hF;
    repeat (4) @(negedge clk);
    check("lat_idle_irq", {31'h0, irq}, 32'h0);
    in_port = 4'hE;
    repeat (2) @(negedge clk);
    check("lat_early_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("lat_exact_irq", {31'h0, irq}, 32'h1);
    in_port = 4'hF;
    repeat (4) @(negedge clk);
    bus_read(2'd3);
    check("rise_ignored_cap", readdata, 32'h1);

    // Set and W1C of bit 0 in the same clock: set wins
    bus_write(2'd3, 32'hF);
    check("pre_collide_irq", {31'h0, irq}, 32'h0);
    in_port = 4'hE;
    repeat (2) @(negedge clk);
    bus_write(2'd3, 32'h1);
    check("collide_irq", {31'h0, irq}, 32'h1);
    bus_read(2'd3);
    check("collide_cap", readdata, 32'h1);

    // readdata holds while chipselect is low
    bus_write(2'd3, 32'h1);
    check("clear_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    check("rd_hold", readdata, 32'h1);

    // Rising edge seen only by the any-edge instance
    bus_write(2'd3, 32'hF);
    in_port = 4'hF;
    repeat (4) @(negedge clk);
    bus_read(2'd3);
    check("rise_fall_only", readdata, 32'h0);
    check("rise_any_edge", readdata_a, 32'h1);

    // Reset mid-capture clears everything in one clock and re-arms
    in_port = 4'hE;
    repeat (4) @(negedge clk);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_reset_irq", {31'h0, irq}, 32'h0);
    check("mid_reset_rd", readdata, 32'h0);
    repeat (5) @(negedge clk);
    bus_read(2'd3);
    check("rearm_cap", readdata, 32'h0);
    check("rearm_cap_any", readdata_a, 32'h0);
    bus_read(2'd2);
    check("rearm_mask", readdata, 32'h0);
    bus_read(2'd0);
    check("rearm_data", readdata, 32'hE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
